// File: rtl/rv32_pkg.sv
// RV32I opcode constants, reset NOP and the decode-side selector enums
// shared by the decode stage and its immediate generator.
package rv32_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef enum logic [1:0] {
        A1_ZERO,
        A1_RS1,
        A1_PC
    } a1_sel_e;

    typedef enum logic [1:0] {
        A2_ZERO,
        A2_RS2,
        A2_IMM,
        A2_FOUR
    } a2_sel_e;

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate generator: sign-extends the I/S/B/U/J field
// of an instruction according to the selected format.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] ins,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        unique case (fmt)
            IMM_I:    imm = {{20{ins[31]}}, ins[31:20]};
            IMM_S:    imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:    imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:    imm = {ins[31:12], 12'b0};
            IMM_J:    imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_NONE: imm = '0;
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage_fwd.sv
// RV32I decode stage: one-entry valid/ready register, opcode decode, operand
// forwarding from NUM_FWD writeback sources and load-use stall.
module decode_stage_fwd
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN    = 32,
    parameter int unsigned     NUM_FWD = 2,
    parameter logic [XLEN-1:0] RST_PC  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             ins_in,
    input  logic [XLEN-1:0]         pc_in,
    input  logic                    flush,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    input  logic [XLEN-1:0]         rso1,
    input  logic [XLEN-1:0]         rso2,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [5*NUM_FWD-1:0]    fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    ex_load,
    input  logic [4:0]              ex_load_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             ins_out,
    output logic [XLEN-1:0]         pc_out,
    output logic [XLEN-1:0]         imm_out,
    output logic [XLEN-1:0]         alu_in1,
    output logic [XLEN-1:0]         alu_in2,
    output logic                    illegal
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("decode_stage_fwd: XLEN must be 32");
    end

    logic            vld_q, vld_d;
    logic [31:0]     ins_q, ins_d;
    logic [XLEN-1:0] pc_q, pc_d;

    logic [6:0]  opcode;
    logic        legal, rs1_used, rs2_used, hazard;
    imm_fmt_e    fmt;
    a1_sel_e     a1_sel;
    a2_sel_e     a2_sel;
    logic [31:0] imm;
    logic [XLEN-1:0] src1, src2;

    assign opcode   = ins_q[6:0];
    assign rs1_addr = ins_q[19:15];
    assign rs2_addr = ins_q[24:20];

    always_comb begin
        legal    = 1'b1;
        fmt      = IMM_NONE;
        a1_sel   = A1_ZERO;
        a2_sel   = A2_ZERO;
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        unique case (opcode)
            OP:                  begin a1_sel = A1_RS1; a2_sel = A2_RS2; rs2_used = 1'b1; end
            OP_IMM, LOAD:        begin fmt = IMM_I; a1_sel = A1_RS1; a2_sel = A2_IMM; end
            STORE:               begin fmt = IMM_S; a1_sel = A1_RS1; a2_sel = A2_IMM; rs2_used = 1'b1; end
            BRANCH:              begin fmt = IMM_B; a1_sel = A1_RS1; a2_sel = A2_RS2; rs2_used = 1'b1; end
            LUI:                 begin fmt = IMM_U; a2_sel = A2_IMM; rs1_used = 1'b0; end
            AUIPC:               begin fmt = IMM_U; a1_sel = A1_PC; a2_sel = A2_IMM; rs1_used = 1'b0; end
            JAL:                 begin fmt = IMM_J; a1_sel = A1_PC; a2_sel = A2_FOUR; rs1_used = 1'b0; end
            JALR:                begin fmt = IMM_I; a1_sel = A1_PC; a2_sel = A2_FOUR; end
            default:             legal = 1'b0;
        endcase
    end

    rv32_imm_gen u_imm_gen (
        .ins (ins_q),
        .fmt (fmt),
        .imm (imm)
    );

    // Priority chain built from the oldest source inwards so index 0 is applied last.
    for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
        logic [XLEN-1:0] nxt1, nxt2, c1, c2;
        if (i == NUM_FWD - 1) begin : g_last
            assign nxt1 = rso1;
            assign nxt2 = rso2;
        end else begin : g_mid
            assign nxt1 = g_fwd[i+1].c1;
            assign nxt2 = g_fwd[i+1].c2;
        end
        always_comb begin
            c1 = (fwd_we[i] && (fwd_rd[5*i +: 5] == rs1_addr)) ? fwd_data[XLEN*i +: XLEN] : nxt1;
            c2 = (fwd_we[i] && (fwd_rd[5*i +: 5] == rs2_addr)) ? fwd_data[XLEN*i +: XLEN] : nxt2;
        end
    end

    always_comb begin
        src1 = (rs1_addr == 5'd0) ? '0 : g_fwd[0].c1;
        src2 = (rs2_addr == 5'd0) ? '0 : g_fwd[0].c2;
    end

    always_comb begin
        alu_in1 = '0;
        alu_in2 = '0;
        unique case (a1_sel)
            A1_RS1:  alu_in1 = src1;
            A1_PC:   alu_in1 = pc_q;
            default: alu_in1 = '0;
        endcase
        unique case (a2_sel)
            A2_RS2:  alu_in2 = src2;
            A2_IMM:  alu_in2 = imm;
            A2_FOUR: alu_in2 = 32'd4;
            default: alu_in2 = '0;
        endcase
    end

    always_comb begin
        hazard = vld_q && ex_load && (ex_load_rd != 5'd0) &&
                 ((rs1_used && (rs1_addr == ex_load_rd)) ||
                  (rs2_used && (rs2_addr == ex_load_rd)));
        out_valid = vld_q && !hazard;
        in_ready  = !vld_q || (out_ready && !hazard);
        illegal   = vld_q && !legal;
        imm_out   = imm;
        ins_out   = ins_q;
        pc_out    = pc_q;
    end

    always_comb begin
        vld_d = vld_q;
        ins_d = ins_q;
        pc_d  = pc_q;
        if (flush) begin
            vld_d = 1'b0;
        end else if (in_valid && in_ready) begin
            vld_d = 1'b1;
            ins_d = ins_in;
            pc_d  = pc_in;
        end else if (out_valid && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ins_q <= NOP_INSN;
            pc_q  <= RST_PC;
        end else begin
            vld_q <= vld_d;
            ins_q <= ins_d;
            pc_q  <= pc_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed self-checking bench for decode_stage_fwd: hand-computed decode,
// forwarding, load-use stall, backpressure, flush and reset vectors.
module tb_decode_stage_fwd;

    localparam logic [31:0] RST_PC_T = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ins_in;
    logic [31:0] pc_in;
    logic        flush;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rso1, rso2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        ex_load;
    logic [4:0]  ex_load_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ins_out, pc_out, imm_out, alu_in1, alu_in2;
    logic        illegal;

    int n_asserts = 0;
    int n_fail    = 0;

    decode_stage_fwd #(.XLEN(32), .NUM_FWD(2), .RST_PC(RST_PC_T)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ins_in     (ins_in),
        .pc_in      (pc_in),
        .flush      (flush),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rso1       (rso1),
        .rso2       (rso2),
        .fwd_we     (fwd_we),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .ex_load    (ex_load),
        .ex_load_rd (ex_load_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ins_out    (ins_out),
        .pc_out     (pc_out),
        .imm_out    (imm_out),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
        in_valid = 1'b1;
        ins_in   = ins;
        pc_in    = pc;
        tick();
        in_valid = 1'b0;
        settle();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; ins_in = '0; pc_in = '0; flush = 1'b0;
        rso1 = '0; rso2 = '0; fwd_we = '0; fwd_rd = '0; fwd_data = '0;
        ex_load = 1'b0; ex_load_rd = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_ins_out",   ins_out, 32'h0000_0013);
        chk("rst_pc_out",    pc_out, RST_PC_T);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
        chk("rst_illegal",   {31'b0, illegal}, 32'd0);
        chk("rst_alu_in1",   alu_in1, 32'd0);
        chk("rst_alu_in2",   alu_in2, 32'd0);

        // addi x1,x0,5
        issue(32'h0050_0093, 32'h0);
        chk("addi_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_alu1",  alu_in1, 32'd0);
        chk("addi_alu2",  alu_in2, 32'd5);
        chk("addi_imm",   imm_out, 32'd5);

        // add x3,x1,x2 with forwarding
        rso1 = 32'd7; rso2 = 32'd9;
        issue(32'h0020_81B3, 32'h4);
        fwd_we = 2'b11; fwd_rd = {5'd1, 5'd1}; fwd_data = {32'h22, 32'h11};
        settle();
        chk("add_ins_out",  ins_out, 32'h0020_81B3);
        chk("fwd_prio_a1",  alu_in1, 32'h11);
        chk("fwd_prio_a2",  alu_in2, 32'd9);
        chk("add_rs1_addr", {27'b0, rs1_addr}, 32'd1);
        chk("add_rs2_addr", {27'b0, rs2_addr}, 32'd2);
        chk("add_imm",      imm_out, 32'd0);
        fwd_we = 2'b10;
        settle();
        chk("fwd_src1_a1", alu_in1, 32'h22);
        fwd_we = 2'b11; fwd_rd = {5'd2, 5'd1};
        settle();
        chk("fwd_split_a1", alu_in1, 32'h11);
        chk("fwd_split_a2", alu_in2, 32'h22);
        fwd_we = 2'b00;
        settle();
        chk("nofwd_a1", alu_in1, 32'd7);
        chk("nofwd_a2", alu_in2, 32'd9);

        // load-use hazard
        ex_load = 1'b1; ex_load_rd = 5'd1;
        settle();
        chk("hz_rs1_valid", {31'b0, out_valid}, 32'd0);
        chk("hz_rs1_ready", {31'b0, in_ready}, 32'd0);
        ex_load_rd = 5'd2;
        settle();
        chk("hz_rs2_valid", {31'b0, out_valid}, 32'd0);
        ex_load_rd = 5'd3;
        settle();
        chk("hz_nomatch_valid", {31'b0, out_valid}, 32'd1);
        ex_load_rd = 5'd1;
        tick();
        chk("hz_hold_ins",   ins_out, 32'h0020_81B3);
        chk("hz_hold_valid", {31'b0, out_valid}, 32'd0);
        ex_load = 1'b0;
        settle();
        chk("hz_release_valid", {31'b0, out_valid}, 32'd1);
        chk("hz_release_ready", {31'b0, in_ready}, 32'd1);

        // beq x1,x2,-4
        issue(32'hFE20_8EE3, 32'h200);
        chk("beq_imm",  imm_out, 32'hFFFF_FFFC);
        chk("beq_alu1", alu_in1, 32'd7);
        chk("beq_alu2", alu_in2, 32'd9);
        chk("beq_pc",   pc_out, 32'h200);

        // jal x1,+8 at 0x100
        issue(32'h0080_00EF, 32'h100);
        chk("jal_alu1", alu_in1, 32'h100);
        chk("jal_alu2", alu_in2, 32'd4);
        chk("jal_imm",  imm_out, 32'd8);

        // addi x5,x0,-1 while a source targets x0
        fwd_we = 2'b01; fwd_rd = {5'd0, 5'd0}; fwd_data = {32'h0, 32'hDEAD};
        issue(32'hFFF0_0293, 32'h104);
        chk("x0_nofwd_a1", alu_in1, 32'd0);
        chk("addi_neg_a2", alu_in2, 32'hFFFF_FFFF);
        fwd_we = 2'b00;

        // jalr x1,12(x5)
        issue(32'h00C2_80E7, 32'h300);
        chk("jalr_alu1", alu_in1, 32'h300);
        chk("jalr_alu2", alu_in2, 32'd4);
        chk("jalr_imm",  imm_out, 32'd12);

        // lui x2,0x12345
        issue(32'h1234_5137, 32'h304);
        chk("lui_alu1", alu_in1, 32'd0);
        chk("lui_alu2", alu_in2, 32'h1234_5000);

        // sw x2,-8(x1)
        issue(32'hFE20_AC23, 32'h308);
        chk("sw_alu1", alu_in1, 32'd7);
        chk("sw_alu2", alu_in2, 32'hFFFF_FFF8);
        chk("sw_imm",  imm_out, 32'hFFFF_FFF8);

        // illegal opcode
        issue(32'hFFFF_FFFF, 32'h30C);
        chk("ill_flag",  {31'b0, illegal}, 32'd1);
        chk("ill_valid", {31'b0, out_valid}, 32'd1);
        chk("ill_alu1",  alu_in1, 32'd0);
        chk("ill_alu2",  alu_in2, 32'd0);
        tick();
        chk("ill_drained_valid", {31'b0, out_valid}, 32'd0);
        chk("ill_drained_flag",  {31'b0, illegal}, 32'd0);

        // backpressure then streaming
        out_ready = 1'b0;
        issue(32'h0050_0093, 32'h10);
        in_valid = 1'b1; ins_in = 32'h00A0_0113; pc_in = 32'h14;
        settle();
        chk("bp_in_ready",  {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_ins",   ins_out, 32'h0050_0093);
            chk("bp_hold_pc",    pc_out, 32'h10);
            chk("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        ins_in = 32'h00F0_0193; pc_in = 32'h18;
        settle();
        chk("stream_b_ins", ins_out, 32'h00A0_0113);
        chk("stream_b_pc",  pc_out, 32'h14);
        chk("stream_b_vld", {31'b0, out_valid}, 32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        chk("stream_c_pc",  pc_out, 32'h18);
        chk("stream_c_vld", {31'b0, out_valid}, 32'd1);
        tick();
        chk("stream_drain_vld", {31'b0, out_valid}, 32'd0);

        // flush with a simultaneous offer
        issue(32'h0050_0093, 32'h40);
        flush = 1'b1; in_valid = 1'b1; ins_in = 32'h00A0_0113; pc_in = 32'h44;
        settle();
        chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        settle();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_pc",    pc_out, 32'h40);

        // reset mid-stream
        issue(32'h00A0_0113, 32'h50);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ins",   ins_out, 32'h0000_0013);
        chk("mid_rst_pc",    pc_out, RST_PC_T);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
